// File: rtl/test_basic3_sink_pkg.sv
// Shared types for the TestBasic3 sink: section enum and 32-bit signed limits.
// Referenced by test_basic3_sink and test_basic3_sink_add.
package testbasic3_sink_types;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } TestBasic3Sink_SECTIONS;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/test_basic3_sink_add.sv
// 32-bit signed adder; clamps to INT_MAX/INT_MIN when
// TEST_BASIC3_SINK_SATURATE_EN is defined, otherwise wraps modulo 2^32.
module test_basic3_sink_add
  import testbasic3_sink_types::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  logic [31:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef TEST_BASIC3_SINK_SATURATE_EN
  logic w_ovf;

  // Overflow only when both operands share a sign the result lost
  assign w_ovf = (i_a[31] == i_b[31]) &&
                 (w_raw[31] != i_a[31]);

  always_comb begin
    o_sum = w_raw;
    if (w_ovf) begin
      o_sum = i_a[31] ? INT_MIN : INT_MAX;
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/test_basic3_sink.sv
// Windowed accumulator sink: sums WINDOW handshaken samples, then offers the sum.
// Overflow mode selected by TEST_BASIC3_SINK_SATURATE_EN (see adder).
module test_basic3_sink
  import testbasic3_sink_types::*;
#(
  parameter int WINDOW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] b_in,
  input  logic        b_in_sync,
  output logic        b_in_notify,
  output logic [31:0] s_out,
  input  logic        s_out_sync,
  output logic        s_out_notify
);

  localparam int CW = $clog2(WINDOW) + 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  TestBasic3Sink_SECTIONS r_state;
  TestBasic3Sink_SECTIONS w_state_n;

  logic [31:0]   r_acc;
  logic [31:0]   w_acc_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [31:0]   r_sout;
  logic [31:0]   w_sout_n;
  logic          r_in_rdy;
  logic          r_out_vld;
  logic [31:0]   w_sum;

  test_basic3_sink_add u_add (
    .i_a   (r_acc),
    .i_b   (b_in),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_cnt_n   = r_cnt;
    w_sout_n  = r_sout;
    unique case (r_state)
      READ: begin
        if (b_in_sync) begin
          if (r_cnt == LAST) begin
            w_state_n = WRITE;
            w_sout_n  = w_sum;
          end else begin
            w_acc_n = w_sum;
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      WRITE: begin
        if (s_out_sync) begin
          w_state_n = READ;
          w_acc_n   = '0;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= READ;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sout    <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_acc     <= w_acc_n;
      r_cnt     <= w_cnt_n;
      r_sout    <= w_sout_n;
      r_in_rdy  <= (w_state_n == READ);
      r_out_vld <= (w_state_n == WRITE);
    end
  end

  assign b_in_notify  = r_in_rdy;
  assign s_out_notify = r_out_vld;
  assign s_out        = r_sout;

endmodule

// File: tb/tb_test_basic3_sink.sv
// Bench for test_basic3_sink: WINDOW=4 and WINDOW=1 instances, a
// list-based reference model compared every cycle, plus literal pins.
module tb_test_basic3_sink;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] b0, s0, b1, s1;
  logic        bs0, bn0, ss0, sn0;
  logic        bs1, bn1, ss1, sn1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  test_basic3_sink #(.WINDOW(4)) u_w4 (
    .clk(clk), .rst(rst),
    .b_in(b0), .b_in_sync(bs0), .b_in_notify(bn0),
    .s_out(s0), .s_out_sync(ss0), .s_out_notify(sn0)
  );

  test_basic3_sink #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst(rst),
    .b_in(b1), .b_in_sync(bs1), .b_in_notify(bn1),
    .s_out(s1), .s_out_sync(ss1), .s_out_notify(sn1)
  );

  // Reference model: collected samples, pending flag, held result
  int          win  [2];
  int          mcnt [2];
  int          msmp [2][256];
  bit          mpend[2];
  logic [31:0] msout[2];
  bit          mvalid = 0;

  function automatic logic [31:0] madd(logic [31:0] a, logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef TEST_BASIC3_SINK_SATURATE_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  task automatic mstep(input int k, input logic sy,
                       input logic [31:0] b, input logic osy);
    logic [31:0] acc;
    if (!rst) begin
      mcnt[k] = 0; mpend[k] = 0; msout[k] = '0;
    end else if (!mpend[k]) begin
      if (sy) begin
        msmp[k][mcnt[k]] = int'(b);
        mcnt[k]++;
        if (mcnt[k] == win[k]) begin
          acc = '0;
          for (int i = 0; i < win[k]; i++) acc = madd(acc, msmp[k][i]);
          msout[k] = acc;
          mpend[k] = 1;
          mcnt[k]  = 0;
        end
      end
    end else if (osy) begin
      mpend[k] = 0;
    end
  endtask

  initial begin
    win[0] = 4;
    win[1] = 1;
  end

  always @(posedge clk) begin
    mstep(0, bs0, b0, ss0);
    mstep(1, bs1, b1, ss1);
    if (!rst) mvalid = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("w4_in_notify",  32'(bn0), 32'(!mpend[0]));
      chk("w4_out_notify", 32'(sn0), 32'(mpend[0]));
      chk("w4_s_out",      s0,       msout[0]);
      chk("w1_in_notify",  32'(bn1), 32'(!mpend[1]));
      chk("w1_out_notify", 32'(sn1), 32'(mpend[1]));
      chk("w1_s_out",      s1,       msout[1]);
    end
  end

  task automatic push4(input logic [31:0] v);
    @(negedge clk);
    b0 = v; bs0 = 1'b1;
  endtask

  initial begin
    logic [31:0] ovf_exp;
    bit          hit;
    rst = 1'b0;
    b0 = '0; bs0 = 1'b0; ss0 = 1'b1;
    b1 = '0; bs1 = 1'b0; ss1 = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_s_out", s0, 32'd0);
    chk("rst_in_notify", 32'(bn0), 32'd1);
    chk("rst_out_notify", 32'(sn0), 32'd0);

    // 1,2,3,4 back-to-back; first input on first edge out of reset
    @(negedge clk);
    rst = 1'b1; b0 = 32'd1; bs0 = 1'b1;
    push4(32'd2); push4(32'd3); push4(32'd4);
    @(negedge clk);
    bs0 = 1'b0;
    chk("seq_sum", s0, 32'd10);
    chk("seq_valid", 32'(sn0), 32'd1);
    @(negedge clk);
    chk("seq_one_cycle", 32'(sn0), 32'd0);
    chk("seq_ready_back", 32'(bn0), 32'd1);

    // gapped inputs 5,-7,100,2
    for (int i = 0; i < 4; i++) begin
      push4(i == 0 ? 32'd5 : i == 1 ? -32'sd7 :
            i == 2 ? 32'd100 : 32'd2);
      @(negedge clk);
      bs0 = 1'b0;
      if (i == 3) chk("gap_sum", s0, 32'd100);
      repeat (2) @(negedge clk);
    end

    // backpressure for 5 cycles with producer offering 50
    ss0 = 1'b0;
    push4(32'd1); push4(32'd1); push4(32'd1); push4(32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b0 = 32'd50; bs0 = 1'b1;
      chk("bp_in_notify", 32'(bn0), 32'd0);
      chk("bp_s_out", s0, 32'd4);
    end
    @(negedge clk);
    ss0 = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    bs0 = 1'b0;
    chk("bp_next_window", s0, 32'd200);
    @(negedge clk);

    // overflow
`ifdef TEST_BASIC3_SINK_SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h8000_0010;
`endif
    push4(32'h7FFF_FFF0); push4(32'h20); push4(32'd0); push4(32'd0);
    @(negedge clk);
    bs0 = 1'b0;
    chk("ovf_sum", s0, ovf_exp);

    // reset while a result is pending
    ss0 = 1'b0;
    push4(32'd7); push4(32'd8); push4(32'd9); push4(32'd10);
    @(negedge clk);
    bs0 = 1'b0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (sn0) hit = 1;
      else @(negedge clk);
    end
    if (!hit) begin
      nvec++; nerr++;
      $display("FAIL rstw_wait: got no result within 10 cycles, expected one");
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; ss0 = 1'b1;
    chk("rstw_s_out", s0, 32'd0);
    chk("rstw_out_notify", 32'(sn0), 32'd0);
    chk("rstw_in_notify", 32'(bn0), 32'd1);
    b0 = 32'd1; bs0 = 1'b1;
    push4(32'd1); push4(32'd1); push4(32'd1);
    @(negedge clk);
    bs0 = 1'b0;
    chk("rstw_sum", s0, 32'd4);

    // WINDOW=1: 9 then -3
    @(negedge clk);
    b1 = 32'd9; bs1 = 1'b1;
    @(negedge clk);
    b1 = -32'sd3;
    chk("w1_first", s1, 32'd9);
    chk("w1_first_vld", 32'(sn1), 32'd1);
    @(negedge clk);
    bs1 = 1'b0;
    chk("w1_gap_ready", 32'(bn1), 32'd1);
    @(negedge clk);
    b1 = -32'sd3; bs1 = 1'b1;
    @(negedge clk);
    bs1 = 1'b0;
    chk("w1_second", s1, 32'hFFFF_FFFD);
    chk("w1_second_vld", 32'(sn1), 32'd1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
